// File: rtl/ram_pkg.sv
// Shared sizing constants for the single-port scratch RAM so that every user
// sizes its address and data buses the same way.
package ram_pkg;

   localparam int RAM_DATA_WIDTH = 8;
   localparam int RAM_ADDR_WIDTH = 10;
   localparam int RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

endpackage : ram_pkg

// File: rtl/ram.sv
// Single-port synchronous RAM with a registered, read-first output port.
// Reset clears only the output register and blocks a write on the same edge.
module ram
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH = RAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
   parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  write_enable,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  rst
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_out_d;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  wr_en_d;

   // Write qualification and read-first data selection (old word is read before the write lands)
   always_comb begin
      wr_en_d    = write_enable & ~rst;
      data_out_d = mem_q[address];
   end

   // Storage array: no reset so synthesis can map it onto block RAM
   always_ff @(posedge clk) begin
      if (wr_en_d) begin
         mem_q[address] <= data_in;
      end
   end

   // Registered read port with synchronous clear
   always_ff @(posedge clk) begin
      if (rst) begin
         data_out_q <= '0;
      end else begin
         data_out_q <= data_out_d;
      end
   end

   assign data_out = data_out_q;

endmodule : ram

// File: tb/tb_ram.sv
// Self-checking bench for ram: directed vector table, hand-written
// back-to-back sequences and a randomized run against a memory model.
module tb_ram;

   localparam int DW = 8;
   localparam int AW = 10;
   localparam int DEPTH = 1 << AW;

   logic          clk;
   logic          rst;
   logic          write_enable;
   logic [AW-1:0] address;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;

   int n_cmp;
   int n_err;

   // Behavioural model: word storage plus a flag telling whether a word has ever been written.
   logic [DW-1:0] model_mem   [DEPTH];
   bit            model_known [DEPTH];
   logic [DW-1:0] model_exp;
   bit            model_exp_known;

   typedef struct {
      bit            r;
      bit            we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] exp;
      int            kind;   // 0 no check, 1 must equal exp, 2 must differ from 8'h11 and 8'hEE
      string         name;
   } vec_t;

   vec_t vecs[$];

   ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .write_enable (write_enable),
      .address      (address),
      .data_in      (data_in),
      .data_out     (data_out),
      .rst          (rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle, let the model predict the output of this edge, then sample 1 time unit later.
   task automatic step(input bit r, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rst          = r;
      write_enable = we;
      address      = a;
      data_in      = d;
      if (r) begin
         model_exp       = '0;
         model_exp_known = 1'b1;
      end else begin
         model_exp       = model_mem[a];
         model_exp_known = model_known[a];
      end
      @(posedge clk);
      if (we && !r) begin
         model_mem[a]   = d;
         model_known[a] = 1'b1;
      end
      #1;
   endtask

   task automatic check_eq(input string name, input logic [DW-1:0] exp);
      n_cmp++;
      if (data_out !== exp) begin
         n_err++;
         $display("FAIL %s: data_out=%h expected=%h", name, data_out, exp);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < DEPTH; i++) begin
         model_known[i] = 1'b0;
         model_mem[i]   = '0;
      end

      vecs.push_back('{1'b1, 1'b0, 10'd0,    8'h00, 8'h00, 1, "reset_1"});
      vecs.push_back('{1'b1, 1'b0, 10'd0,    8'h00, 8'h00, 1, "reset_2"});
      vecs.push_back('{1'b0, 1'b1, 10'd55,   8'h56, 8'h00, 0, "wr55"});
      vecs.push_back('{1'b0, 1'b0, 10'd55,   8'h00, 8'h56, 1, "rd55"});
      vecs.push_back('{1'b0, 1'b1, 10'd66,   8'h36, 8'h00, 0, "wr66"});
      vecs.push_back('{1'b0, 1'b0, 10'd66,   8'h00, 8'h36, 1, "rd66"});
      vecs.push_back('{1'b0, 1'b0, 10'd55,   8'h00, 8'h56, 1, "rd55_kept"});
      vecs.push_back('{1'b0, 1'b1, 10'd55,   8'hA5, 8'h56, 1, "collide_old"});
      vecs.push_back('{1'b0, 1'b0, 10'd55,   8'h00, 8'hA5, 1, "collide_new"});
      vecs.push_back('{1'b0, 1'b1, 10'd0,    8'h11, 8'h00, 0, "wr0"});
      vecs.push_back('{1'b0, 1'b1, 10'd1023, 8'hEE, 8'h00, 0, "wr1023"});
      vecs.push_back('{1'b0, 1'b0, 10'd0,    8'h00, 8'h11, 1, "rd0"});
      vecs.push_back('{1'b0, 1'b0, 10'd1023, 8'h00, 8'hEE, 1, "rd1023"});
      vecs.push_back('{1'b0, 1'b0, 10'd512,  8'h00, 8'h00, 2, "rd512_alias"});
      vecs.push_back('{1'b1, 1'b1, 10'd55,   8'hFF, 8'h00, 1, "rst_wr_blocked"});
      vecs.push_back('{1'b0, 1'b0, 10'd55,   8'h00, 8'hA5, 1, "retained55"});
      vecs.push_back('{1'b0, 1'b0, 10'd0,    8'h00, 8'h11, 1, "retained0"});

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].we, vecs[i].a, vecs[i].d);
         if (vecs[i].kind == 1) begin
            check_eq(vecs[i].name, vecs[i].exp);
         end else if (vecs[i].kind == 2) begin
            n_cmp++;
            if (data_out === 8'h11 || data_out === 8'hEE) begin
               n_err++;
               $display("FAIL %s: data_out=%h must differ from 11 and ee", vecs[i].name, data_out);
            end
         end
      end

      // Back-to-back writes, then back-to-back reads with one-cycle latency.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, AW'(i), DW'(i * 3));
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, AW'(i), 8'h00);
         check_eq($sformatf("b2b_rd%0d", i), DW'(i * 3));
      end

      // Output holds between edges: change inputs mid-cycle and resample before the next edge.
      address = 10'd1023;
      write_enable = 1'b1;
      data_in = 8'h77;
      #2;
      check_eq("hold_between_edges", 8'h2D);
      write_enable = 1'b0;

      // Randomized traffic against the model, concentrated on few addresses to provoke collisions.
      for (int c = 0; c < 3000; c++) begin
         bit            r;
         bit            we;
         logic [AW-1:0] a;
         r  = ($urandom_range(31) == 0);
         we = $urandom_range(1);
         if ($urandom_range(3) == 0) a = AW'($urandom);
         else                        a = AW'($urandom_range(31));
         step(r, we, a, DW'($urandom));
         if (model_exp_known) begin
            check_eq($sformatf("rand%0d_a%0d", c, a), model_exp);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_ram
